// File: rtl/color_seq_gen_if.sv
// Handshake bundle between the game FSM (master) and the colour source (slave).
// The master raises pulseSeq to request a colour. The slave answers with colorSeq,
// qualified by colorPronto.
interface color_seq_gen_if;
  logic       pulseSeq;
  logic       mix;
  logic       colorPronto;
  logic [3:0] colorSeq;

  modport master (
    output pulseSeq,
    output mix,
    input  colorPronto,
    input  colorSeq
  );

  modport slave (
    input  pulseSeq,
    input  mix,
    output colorPronto,
    output colorSeq
  );
endinterface

// File: rtl/color_seq_gen.sv
// Pseudo-random colour source for the Genius game.
// A free-running 16-bit Galois LFSR is perturbed by the player-button entropy bit.
// Each request draws one colour from the LFSR and limits runs of the same colour.
// The colour is presented for a fixed number of cycles. A new colour is served only
// after the request has been dropped.
module color_seq_gen #(
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned MAX_REPEAT  = 2
) (
  input  logic           clock,
  input  logic           reset,
  color_seq_gen_if.slave seq_if
);

  localparam logic [15:0] TAPS      = 16'hB400;
  localparam logic [3:0]  HOLD_LOAD = 4'(HOLD_CYCLES - 1);
  localparam logic [2:0]  REP_LIMIT = 3'(MAX_REPEAT);
  localparam bit          REP_EN    = (MAX_REPEAT != 0);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    DRAW      = 2'd1,
    HOLD      = 2'd2,
    WAIT_DROP = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] lfsr;
  logic [3:0]  hold_cnt;
  logic [3:0]  last;
  logic [2:0]  rep_cnt;
  logic [2:0]  rep_nxt;
  logic [3:0]  raw_col;
  logic [3:0]  emit_col;
  logic        pronto_q;
  logic [3:0]  seq_q;

  // One Galois step. An all-zero result would lock the register, so it reloads the seed.
  function automatic logic [15:0] lfsr_step(input logic [15:0] cur, input logic m);
    logic [15:0] nxt;
    nxt = (cur >> 1) ^ ({16{cur[0] ^ m}} & TAPS);
    return (nxt == 16'h0000) ? SEED : nxt;
  endfunction

  // Colour ring red -> green -> yellow -> blue -> red.
  function automatic logic [3:0] ring_next(input logic [3:0] c);
    return (c == 4'd4) ? 4'd1 : c + 4'd1;
  endfunction

  // The run-length counter saturates at 7.
  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // Colour drawn in the DRAW cycle, with the run-length limiter applied.
  always_comb begin
    raw_col  = {2'b00, lfsr[1:0]} + 4'd1;
    emit_col = raw_col;
    if (REP_EN && (raw_col == last) && (rep_cnt == REP_LIMIT)) begin
      emit_col = ring_next(raw_col);
    end
    rep_nxt = (emit_col == last) ? sat_inc(rep_cnt) : 3'd1;
  end

  // Next-state logic of the request handshake.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (seq_if.pulseSeq) state_nxt = DRAW;
      DRAW:      state_nxt = HOLD;
      HOLD:      if (hold_cnt == 4'd0) state_nxt = WAIT_DROP;
      WAIT_DROP: if (!seq_if.pulseSeq) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The LFSR free-runs in every state so that request timing adds entropy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= lfsr_step(lfsr, seq_if.mix);
  end

  // Registered outputs, hold timer and colour history.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pronto_q <= 1'b0;
      seq_q    <= 4'b0000;
      hold_cnt <= 4'd0;
      last     <= 4'd0;
      rep_cnt  <= 3'd0;
    end else begin
      case (state)
        DRAW: begin
          seq_q    <= emit_col;
          pronto_q <= 1'b1;
          hold_cnt <= HOLD_LOAD;
          last     <= emit_col;
          rep_cnt  <= rep_nxt;
        end
        HOLD: begin
          if (hold_cnt == 4'd0) pronto_q <= 1'b0;
          else                  hold_cnt <= hold_cnt - 4'd1;
        end
        default: pronto_q <= 1'b0;
      endcase
    end
  end

  assign seq_if.colorPronto = pronto_q;
  assign seq_if.colorSeq    = seq_q;

endmodule

// File: tb/tb_color_seq_gen.sv
// Testbench for color_seq_gen. It uses a cycle-level reference model: the LFSR
// recurrence plus the colour and run-length rules, expressed in plain arithmetic.
module tb_color_seq_gen;

  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          HOLD   = 4;
  localparam int          MAXREP = 2;

  logic        clock = 1'b0;
  logic        reset;
  int          n_assert = 0;
  int          n_fail   = 0;
  int          mix_mode = 0;
  int          zero_cnt = 0;
  int          n_pulses = 0;
  logic [15:0] seen     = 16'h0;
  logic [15:0] m_lfsr;
  logic [15:0] m_draw;
  logic [3:0]  m_last;
  int          m_rep;

  color_seq_gen_if bus();

  color_seq_gen #(.SEED(SEED), .HOLD_CYCLES(HOLD), .MAX_REPEAT(MAXREP)) dut (
    .clock  (clock),
    .reset  (reset),
    .seq_if (bus.slave)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] ref_step(input logic [15:0] l, input logic m);
    logic [15:0] n;
    n = (l >> 1) ^ ((l[0] ^ m) ? 16'hB400 : 16'h0000);
    if (n == 16'h0) n = SEED;
    return n;
  endfunction

  // Reference LFSR, plus the value it held during the previous cycle.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr <= SEED;
      m_draw <= SEED;
    end else begin
      m_draw <= m_lfsr;
      m_lfsr <= ref_step(m_lfsr, bus.mix);
    end
  end

  // Entropy driver and lock-up watch.
  always @(negedge clock) begin
    case (mix_mode)
      0:       bus.mix = 1'b0;
      1:       bus.mix = 1'($urandom);
      default: bus.mix = ~bus.mix;
    endcase
    if (dut.lfsr == 16'h0) zero_cnt++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Colour emitted for a draw-cycle LFSR value, given the colour history so far.
  task automatic model_emit(input logic [15:0] l, output logic [3:0] e);
    int c;
    c = int'(l[1:0]) + 1;
    if (MAXREP > 0 && c == int'(m_last) && m_rep == MAXREP) c = c % 4 + 1;
    if (c == int'(m_last)) m_rep = (m_rep < 7) ? m_rep + 1 : 7;
    else                   m_rep = 1;
    m_last = 4'(c);
    e      = 4'(c);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.pulseSeq = 1'b0;
    m_last = 4'd0;
    m_rep  = 0;
    repeat (2) @(negedge clock);
  endtask

  // One request, starting at a negedge with the FSM in IDLE.
  task automatic serve(input bit hold_req, output logic [3:0] col, output logic [15:0] draw_l);
    logic [3:0] e;
    int width;
    bus.pulseSeq = 1'b1;
    @(negedge clock);
    draw_l = dut.lfsr;
    chk("draw_lfsr", 32'(dut.lfsr), 32'(m_lfsr));
    chk("pronto_early", 32'(bus.colorPronto), 32'd0);
    @(negedge clock);
    chk("pronto_rise", 32'(bus.colorPronto), 32'd1);
    model_emit(m_draw, e);
    col = bus.colorSeq;
    chk("color", 32'(bus.colorSeq), 32'(e));
    if (!hold_req) bus.pulseSeq = 1'b0;
    width = bus.colorPronto ? 1 : 0;
    while (bus.colorPronto === 1'b1 && width < 32) begin
      @(negedge clock);
      if (bus.colorPronto === 1'b1) width++;
    end
    chk("pronto_width", 32'(width), 32'(HOLD));
    chk("color_hold", 32'(bus.colorSeq), 32'(e));
    if (width == HOLD) n_pulses++;
    if (col >= 4'd1 && col <= 4'd4) seen[col] = 1'b1;
    if (!hold_req) @(negedge clock);
  endtask

  // Wait until the next draw will see raw red (mix held 0), then request.
  task automatic aim_red(output logic [3:0] col);
    logic [15:0] nx;
    logic [15:0] dl;
    int guard;
    guard = 0;
    nx = ref_step(m_lfsr, 1'b0);
    while (nx[1:0] != 2'b00 && guard < 200) begin
      @(negedge clock);
      guard++;
      nx = ref_step(m_lfsr, 1'b0);
    end
    chk("aim_red_guard", 32'(guard < 200), 32'd1);
    serve(1'b0, col, dl);
  endtask

  initial begin
    logic [3:0]  col;
    logic [15:0] dl;
    int rises;
    logic prev;

    bus.pulseSeq = 1'b0;

    // Scenario 1: reset values, then a request raised at reset release.
    do_reset();
    chk("rst_pronto", 32'(bus.colorPronto), 32'd0);
    chk("rst_seq", 32'(bus.colorSeq), 32'd0);
    chk("rst_lfsr", 32'(dut.lfsr), 32'(SEED));
    reset = 1'b0;
    serve(1'b0, col, dl);
    chk("s1_draw_lfsr", 32'(dl), 32'hE270);
    chk("s1_color", 32'(col), 32'h1);

    // Scenario 2: ten requests with random entropy and random gaps.
    mix_mode = 1;
    n_pulses = 0;
    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clock);
      serve(1'b0, col, dl);
      chk("s2_range", 32'(col >= 4'd1 && col <= 4'd4), 32'd1);
    end
    chk("s2_pulses", 32'(n_pulses), 32'd10);

    // Scenario 4: request held high is served once, then parked.
    serve(1'b1, col, dl);
    rises = 0;
    prev = bus.colorPronto;
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.colorPronto && !prev) rises++;
      prev = bus.colorPronto;
    end
    chk("s4_extra_pulses", 32'(rises), 32'd0);
    chk("s4_pronto_low", 32'(bus.colorPronto), 32'd0);
    chk("s4_lfsr_track", 32'(dut.lfsr), 32'(m_lfsr));
    bus.pulseSeq = 1'b0;
    repeat (2) @(negedge clock);
    serve(1'b0, col, dl);

    // Scenario 3: three raw reds in a row with MAX_REPEAT = 2.
    mix_mode = 0;
    do_reset();
    reset = 1'b0;
    aim_red(col);
    chk("s3_first", 32'(col), 32'h1);
    aim_red(col);
    chk("s3_second", 32'(col), 32'h1);
    aim_red(col);
    chk("s3_third", 32'(col), 32'h2);

    // Scenario 5: reset in the middle of the hold window.
    bus.pulseSeq = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("s5_mid_hold", 32'(bus.colorPronto), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("s5_async_pronto", 32'(bus.colorPronto), 32'd0);
    chk("s5_async_seq", 32'(bus.colorSeq), 32'd0);
    bus.pulseSeq = 1'b0;
    m_last = 4'd0;
    m_rep  = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    serve(1'b0, col, dl);
    chk("s5_draw_lfsr", 32'(dl), 32'hE270);
    chk("s5_color", 32'(col), 32'h1);

    // Scenario 6: toggling entropy over about 10k cycles.
    mix_mode = 2;
    zero_cnt = 0;
    seen = 16'h0;
    for (int i = 0; i < 1250; i++) serve(1'b0, col, dl);
    chk("s6_no_lockup", 32'(zero_cnt), 32'd0);
    chk("s6_all_colors", 32'(seen[4:1]), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
